// File: rtl/cdc_pkg.sv
// Shared types for the source side of the 4-phase req/ack crossing.
// No logic; states are encoded in 2 bits.
// Imported by cdc_hs_src_ctrl.
package cdc_pkg;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_REQ_HI = 2'd1,
    HS_REQ_LO = 2'd2,
    HS_ERR    = 2'd3
  } hs_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer for a single asynchronous bit.
// Latency: SYNC_WIDTH clk_i cycles from d_i to q_o.
// No backpressure; free-running shift chain, synchronous active-low reset.
module sync_ff #(
  parameter int unsigned SYNC_WIDTH = 2,
  parameter logic        RESET_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_WIDTH-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chain <= {SYNC_WIDTH{RESET_VAL}};
    end else begin
      chain <= {chain[SYNC_WIDTH-2:0], d_i};
    end
  end

  assign q_o = chain[SYNC_WIDTH-1];

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// Source-side 4-phase req/ack controller: holds a captured word on data_o while driving req_o.
// Latency: req_o 1 cycle after acceptance; full transfer 2*(SYNC_STAGES+1)+1 cycles with ideal ack.
// Backpressure: s_ready_o is high only in IDLE; a stuck phase times out into a sticky ERR state.
module cdc_hs_src_ctrl
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  input  logic                  clr_timeout_i,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  // A single flop would pass metastability straight into the FSM.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_hs_src_ctrl: SYNC_STAGES must be >= 2");
  end

  localparam int PH_CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PH_W    = (PH_CLOG < 1) ? 1 : PH_CLOG;
  localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [PH_W-1:0] PH_LAST =
    TO_EN ? PH_W'(TIMEOUT_CYCLES - 1) : '0;

  hs_state_e             state, state_nxt;
  logic                  req_q, req_nxt;
  logic                  timeout_q, timeout_nxt;
  logic [PH_W-1:0]       ph_cnt, ph_nxt;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  capture;
  logic                  ph_expired;
  logic                  ack_sync;

  // ack_i is asynchronous; this instance is its only consumer.
  sync_ff #(
    .SYNC_WIDTH (SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .d_i    (ack_i),
    .q_o    (ack_sync)
  );

  // State, request, error flag and both counters; reset aborts any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= HS_IDLE;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      ph_cnt    <= '0;
      xfer_q    <= '0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_nxt;
      timeout_q <= timeout_nxt;
      ph_cnt    <= ph_nxt;
      xfer_q    <= xfer_nxt;
    end
  end

  // Holding register: loads only on acceptance so data_o is stable for the whole handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (capture) begin
      data_q <= s_data_i;
    end
  end

  // Next-state logic; an arriving ack beats a simultaneous timeout.
  always_comb begin
    state_nxt   = state;
    req_nxt     = req_q;
    timeout_nxt = timeout_q;
    ph_nxt      = ph_cnt;
    xfer_nxt    = xfer_q;
    capture     = 1'b0;
    ph_expired  = TO_EN && (ph_cnt == PH_LAST);
    case (state)
      HS_IDLE: begin
        ph_nxt = '0;
        if (s_valid_i) begin
          capture   = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = HS_REQ_HI;
        end
      end
      HS_REQ_HI: begin
        if (ack_sync) begin
          req_nxt   = 1'b0;
          ph_nxt    = '0;
          state_nxt = HS_REQ_LO;
        end else if (ph_expired) begin
          req_nxt     = 1'b0;
          timeout_nxt = 1'b1;
          ph_nxt      = '0;
          state_nxt   = HS_ERR;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      HS_REQ_LO: begin
        if (!ack_sync) begin
          xfer_nxt  = xfer_q + 1'b1;
          ph_nxt    = '0;
          state_nxt = HS_IDLE;
        end else if (ph_expired) begin
          timeout_nxt = 1'b1;
          ph_nxt      = '0;
          state_nxt   = HS_ERR;
        end else begin
          ph_nxt = ph_cnt + 1'b1;
        end
      end
      HS_ERR: begin
        req_nxt     = 1'b0;
        timeout_nxt = 1'b1;
        ph_nxt      = '0;
        // Leave only once the destination has dropped ack, so no stale 4-phase is pending.
        if (clr_timeout_i && !ack_sync) begin
          timeout_nxt = 1'b0;
          state_nxt   = HS_IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        ph_nxt    = '0;
        state_nxt = HS_IDLE;
      end
    endcase
  end

  assign s_ready_o  = (state == HS_IDLE);
  assign busy_o     = (state != HS_IDLE);
  assign req_o      = req_q;
  assign data_o     = data_q;
  assign timeout_o  = timeout_q;
  assign xfer_cnt_o = xfer_q;

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Directed bench for cdc_hs_src_ctrl: main instance (SYNC 2, TIMEOUT 16) and a
// second instance (CNT_WIDTH 2, timeout disabled). Cycle 0 is the accepting cycle;
// outputs are read 1 time unit after each rising edge.
module tb_cdc_hs_src_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        req;
  logic [31:0] data;
  logic        ack;
  logic        ack_drv = 1'b0;
  logic        lb = 1'b1;
  logic        busy;
  logic        timeout;
  logic        clr = 1'b0;
  logic [15:0] cnt;

  assign ack = lb ? req : ack_drv;

  cdc_hs_src_ctrl #(
    .DATA_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .req_o(req), .data_o(data), .ack_i(ack),
    .busy_o(busy), .timeout_o(timeout), .clr_timeout_i(clr), .xfer_cnt_o(cnt)
  );

  // Second instance: narrow counter, timeout disabled
  logic        v2 = 1'b0;
  logic        rdy2;
  logic [31:0] d2 = '0;
  logic        req2;
  logic [31:0] dat2;
  logic        ack2;
  logic        ack2_drv = 1'b0;
  logic        lb2 = 1'b1;
  logic        busy2;
  logic        to2;
  logic        clr2 = 1'b0;
  logic [1:0]  cnt2;

  assign ack2 = lb2 ? req2 : ack2_drv;

  cdc_hs_src_ctrl #(
    .DATA_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0), .CNT_WIDTH(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v2), .s_ready_o(rdy2),
    .s_data_i(d2), .req_o(req2), .data_o(dat2), .ack_i(ack2),
    .busy_o(busy2), .timeout_o(to2), .clr_timeout_i(clr2), .xfer_cnt_o(cnt2)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL reset.req: got %b expected 0", req); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL reset.data: got %h expected 00000000", data); end
    vectors++; if (busy !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("FAIL reset.state: busy %b ready %b expected 0/1", busy, s_ready); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset.timeout: got %b expected 0", timeout); end
    vectors++; if (cnt !== 16'd0 || cnt2 !== 2'd0) begin miscompares++; $display("FAIL reset.cnt: got %0d/%0d expected 0/0", cnt, cnt2); end
    rst = 1'b0;
    exp_cnt = '0;
    tick();
    vectors++; if (s_ready !== 1'b1 || req !== 1'b0) begin miscompares++; $display("FAIL reset.release: ready %b req %b expected 1/0", s_ready, req); end
  endtask

  task automatic test_single();
    logic exp_req, exp_rdy, exp_busy;
    lb = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL single.ready_c0: got %b expected 1", s_ready); end
    tick();
    s_valid = 1'b0;
    s_data = 32'h0BAD_F00D;
    for (int c = 1; c <= 8; c++) begin
      exp_req  = (c <= 3);
      exp_rdy  = (c >= 7);
      exp_busy = (c <= 6);
      if (c == 7) exp_cnt = exp_cnt + 16'd1;
      vectors++; if (req !== exp_req) begin miscompares++; $display("FAIL single.req c%0d: got %b expected %b", c, req, exp_req); end
      vectors++; if (s_ready !== exp_rdy) begin miscompares++; $display("FAIL single.ready c%0d: got %b expected %b", c, s_ready, exp_rdy); end
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL single.busy c%0d: got %b expected %b", c, busy, exp_busy); end
      vectors++; if (data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single.data c%0d: got %h expected deadbeef", c, data); end
      vectors++; if (cnt !== exp_cnt) begin miscompares++; $display("FAIL single.cnt c%0d: got %0d expected %0d", c, cnt, exp_cnt); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int          acc [3];
    int          idx;
    logic [31:0] exp_d;
    logic        acc_now;
    words[0] = 32'hA0A0_0001;
    words[1] = 32'hB0B0_0002;
    words[2] = 32'hC0C0_0003;
    acc[0] = -100; acc[1] = -100; acc[2] = -100;
    idx = 0;
    exp_d = 32'hDEAD_BEEF;
    lb = 1'b1;
    s_valid = 1'b1;
    s_data = words[0];
    for (int c = 0; c < 30; c++) begin
      if (busy) begin
        vectors++; if (data !== exp_d) begin miscompares++; $display("FAIL b2b.data c%0d: got %h expected %h", c, data, exp_d); end
      end
      acc_now = s_valid && s_ready;
      if (acc_now) begin
        acc[idx] = c;
        exp_d = words[idx];
        idx++;
      end
      tick();
      if (acc_now) begin
        if (idx == 3) s_valid = 1'b0;
        else s_data = words[idx];
      end
    end
    exp_cnt = exp_cnt + 16'd3;
    vectors++; if (idx != 3) begin miscompares++; $display("FAIL b2b.accepts: got %0d expected 3", idx); end
    vectors++; if (acc[1] - acc[0] != 7 || acc[2] - acc[1] != 7) begin miscompares++; $display("FAIL b2b.spacing: got %0d,%0d expected 7,7", acc[1] - acc[0], acc[2] - acc[1]); end
    vectors++; if (cnt !== exp_cnt) begin miscompares++; $display("FAIL b2b.cnt: got %0d expected %0d", cnt, exp_cnt); end
    vectors++; if (data !== words[2]) begin miscompares++; $display("FAIL b2b.last: got %h expected %h", data, words[2]); end
  endtask

  task automatic test_stuck_ack_low();
    lb = 1'b0;
    ack_drv = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h1111_2222;
    tick();
    s_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16) begin
        vectors++; if (req !== 1'b1 || timeout !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL stuck_lo.wait c%0d: req %b to %b busy %b expected 1/0/1", c, req, timeout, busy); end
        tick();
      end else begin
        vectors++; if (req !== 1'b0 || timeout !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin miscompares++; $display("FAIL stuck_lo.err c%0d: req %b to %b busy %b rdy %b expected 0/1/1/0", c, req, timeout, busy, s_ready); end
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++; if (timeout !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("FAIL stuck_lo.clear: to %b busy %b rdy %b expected 0/0/1", timeout, busy, s_ready); end
    vectors++; if (cnt !== exp_cnt) begin miscompares++; $display("FAIL stuck_lo.cnt: got %0d expected %0d", cnt, exp_cnt); end
    vectors++; if (data !== 32'h1111_2222) begin miscompares++; $display("FAIL stuck_lo.data: got %h expected 11112222", data); end
  endtask

  task automatic test_stuck_ack_high();
    logic exp_req;
    lb = 1'b0;
    ack_drv = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h3333_4444;
    tick();
    s_valid = 1'b0;
    ack_drv = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      exp_req = (c <= 3);
      vectors++; if (req !== exp_req || timeout !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL stuck_hi.wait c%0d: req %b to %b busy %b expected %b/0/1", c, req, timeout, busy, exp_req); end
      tick();
    end
    vectors++; if (timeout !== 1'b1 || req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL stuck_hi.err: to %b req %b busy %b expected 1/0/1", timeout, req, busy); end
    clr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (timeout !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL stuck_hi.hold k%0d: to %b busy %b expected 1/1", k, timeout, busy); end
    end
    ack_drv = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++; if (busy !== (k < 3) || timeout !== (k < 3)) begin miscompares++; $display("FAIL stuck_hi.release k%0d: busy %b to %b expected %b", k, busy, timeout, (k < 3)); end
    end
    clr = 1'b0;
    vectors++; if (cnt !== exp_cnt) begin miscompares++; $display("FAIL stuck_hi.cnt: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    lb = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h5555_6666;
    tick();
    s_valid = 1'b0;
    tick();
    vectors++; if (req !== 1'b1 || busy !== 1'b1 || data !== 32'h5555_6666) begin miscompares++; $display("FAIL rst_mid.pre: req %b busy %b data %h expected 1/1/55556666", req, busy, data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    vectors++; if (req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid.state: req %b busy %b expected 0/0", req, busy); end
    vectors++; if (data !== 32'h0 || cnt !== exp_cnt) begin miscompares++; $display("FAIL rst_mid.regs: data %h cnt %0d expected 0/0", data, cnt); end
    tick();
    vectors++; if (s_ready !== 1'b1 || req !== 1'b0) begin miscompares++; $display("FAIL rst_mid.after: rdy %b req %b expected 1/0", s_ready, req); end
  endtask

  task automatic test_wrap_and_disable();
    int bad;
    bit done;
    lb2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d2 = 32'(k + 1);
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
      done = 1'b0;
      for (int w = 0; w < 20 && !done; w++) begin
        tick();
        if (!busy2) done = 1'b1;
      end
      vectors++; if (!done) begin miscompares++; $display("FAIL wrap.done k%0d: busy2 %b expected 0", k, busy2); end
    end
    vectors++; if (cnt2 !== 2'd1) begin miscompares++; $display("FAIL wrap.cnt: got %0d expected 1", cnt2); end
    vectors++; if (dat2 !== 32'd5) begin miscompares++; $display("FAIL wrap.data: got %h expected 00000005", dat2); end
    lb2 = 1'b0;
    ack2_drv = 1'b0;
    d2 = 32'h1234_5678;
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (to2 !== 1'b0 || req2 !== 1'b1 || busy2 !== 1'b1) bad++;
      tick();
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL nto.wait: %0d bad cycles expected 0", bad); end
    ack2_drv = 1'b1;
    done = 1'b0;
    for (int w = 0; w < 10 && !done; w++) begin
      tick();
      if (!req2) done = 1'b1;
    end
    vectors++; if (!done) begin miscompares++; $display("FAIL nto.req_fall: req2 %b expected 0", req2); end
    ack2_drv = 1'b0;
    done = 1'b0;
    for (int w = 0; w < 10 && !done; w++) begin
      tick();
      if (!busy2) done = 1'b1;
    end
    vectors++; if (!done || cnt2 !== 2'd2 || to2 !== 1'b0) begin miscompares++; $display("FAIL nto.done: busy2 %b cnt2 %0d to2 %b expected 0/2/0", busy2, cnt2, to2); end
    vectors++; if (dat2 !== 32'h1234_5678) begin miscompares++; $display("FAIL nto.data: got %h expected 12345678", dat2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stuck_ack_low();
    test_stuck_ack_high();
    test_reset_mid();
    test_wrap_and_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
